// File: rtl/mdu_arbiter.sv
// Round-robin arbiter that shares one multiplier and one divider between the alpha and beta pipes.
// Define MDU_ARB_BETA_EN to let beta arbitrate; otherwise alpha owns the MDU outright.
module mdu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        alpha_req,
    input  logic [1:0]  alpha_op,
    input  logic [31:0] alpha_src_a,
    input  logic [31:0] alpha_src_b,
    input  logic        beta_req,
    input  logic [1:0]  beta_op,
    input  logic [31:0] beta_src_a,
    input  logic [31:0] beta_src_b,
    output logic        alpha_grant,
    output logic        beta_grant,
    output logic        alpha_stall_o,
    output logic        beta_stall_o,
    output logic [1:0]  mult_op,
    output logic [1:0]  div_op,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    input  logic        mult_done,
    input  logic        div_done,
    input  logic [63:0] mult_result,
    input  logic [63:0] div_result,
    output logic        hilo_wen,
    output logic [63:0] hilo_result,
    output logic        hilo_busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMMIT,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] result_q;
    logic        mult_done_q;
    logic        div_done_q;
    logic        sel_div;
    logic        done_rise;
    logic        latch_result;
    logic        idle_ok;
    logic        pick_beta;

    assign idle_ok = (state == IDLE) && !flush_i && !rst;

`ifdef MDU_ARB_BETA_EN
    logic rr_q;  // 1: beta wins the next tie

    assign pick_beta     = beta_req && (!alpha_req || rr_q);
    assign beta_grant    = idle_ok && beta_req && pick_beta;
    assign beta_stall_o  = !rst && beta_req && !beta_grant;
`else
    logic unused_beta;

    assign unused_beta   = ^{beta_req, beta_op, beta_src_a, beta_src_b};
    assign pick_beta     = 1'b0;
    assign beta_grant    = 1'b0;
    assign beta_stall_o  = 1'b0;
`endif

    assign alpha_grant   = idle_ok && alpha_req && !pick_beta;
    assign alpha_stall_o = !rst && alpha_req && !alpha_grant;

    // The selected unit's done level is edge-detected against last cycle's value.
    assign sel_div   = op_q[1];
    assign done_rise = sel_div ? (div_done && !div_done_q)
                               : (mult_done && !mult_done_q);

    always_comb begin
        state_next   = state;
        latch_result = 1'b0;
        case (state)
            IDLE: begin
                if (alpha_grant || beta_grant) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = flush_i ? DRAIN : WAIT;
            end
            WAIT: begin
                // A flush coinciding with done drops the result with DRAIN semantics.
                if (flush_i) begin
                    state_next = done_rise ? IDLE : DRAIN;
                end else if (done_rise) begin
                    state_next   = COMMIT;
                    latch_result = 1'b1;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            DRAIN: begin
                if (done_rise) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        mult_op = 2'b00;
        div_op  = 2'b00;
        if (state == ISSUE) begin
            if (sel_div) begin
                div_op  = op_q[0] ? 2'b01 : 2'b10;
            end else begin
                mult_op = op_q[0] ? 2'b01 : 2'b10;
            end
        end
    end

    assign mdu_a       = a_q;
    assign mdu_b       = b_q;
    assign hilo_wen    = (state == COMMIT);
    assign hilo_result = result_q;
    assign hilo_busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            mult_done_q <= 1'b1;
            div_done_q  <= 1'b1;
`ifdef MDU_ARB_BETA_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            mult_done_q <= mult_done;
            div_done_q  <= div_done;
            if (alpha_grant) begin
                op_q <= alpha_op;
                a_q  <= alpha_src_a;
                b_q  <= alpha_src_b;
`ifdef MDU_ARB_BETA_EN
                rr_q <= 1'b1;
            end else if (beta_grant) begin
                op_q <= beta_op;
                a_q  <= beta_src_a;
                b_q  <= beta_src_b;
                rr_q <= 1'b0;
`endif
            end
            if (latch_result) begin
                result_q <= sel_div ? div_result : mult_result;
            end
        end
    end

endmodule
